// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-stage valid/ready register pipeline of two-entry skid buffers with flush and occupancy
module pipe_reg_elastic #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);
  localparam int OW = $clog2(2*DEPTH+1);
  logic [DEPTH-1:0] main_valid, skid_valid;
  logic [DEPTH:0]   vld, rdy;
  logic [WIDTH-1:0] dat [DEPTH+1];
  assign vld    = {main_valid, in_valid};
  assign rdy    = {out_ready, ~skid_valid};
  assign dat[0] = in_data;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             mv, sv, acc, drn;
    logic [WIDTH-1:0] md, sd;
    assign acc = vld[i] & rdy[i];
    assign drn = mv & rdy[i+1];
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mv <= 1'b0;
        sv <= 1'b0;
        md <= RESET_VAL;
        sd <= RESET_VAL;
      end else if (flush) begin
        mv <= 1'b0;
        sv <= 1'b0;
      end else if (!mv || drn) begin
        if (sv) begin
          mv <= 1'b1;
          md <= sd;
          sv <= 1'b0;
        end else begin
          mv <= acc;
          if (acc) md <= dat[i];
        end
      end else if (acc) begin
        sv <= 1'b1;
        sd <= dat[i];
      end
    end
    assign main_valid[i] = mv;
    assign skid_valid[i] = sv;
    assign dat[i+1]      = md;
  end
  assign in_ready  = rdy[0];
  assign out_valid = main_valid[DEPTH-1];
  assign out_data  = dat[DEPTH];
  always_comb begin
    occupancy = '0;
    for (int j = 0; j < DEPTH; j++) occupancy = occupancy + OW'(main_valid[j]) + OW'(skid_valid[j]);
  end
endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb_pipe_reg_elastic: randomized and directed scoreboard bench over three pipe_reg_elastic configurations
module tb_pipe_reg_elastic;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] in_data = '0;
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [23:0] od0, od1;
  logic [7:0]  od2;
  logic [1:0]  oc0;
  logic [2:0]  oc1, oc2;
  logic        ov [3];
  logic        ir [3];
  logic [23:0] od [3];
  logic [2:0]  occ [3];
  logic [23:0] mem [3][8];
  int          cnt [3];
  bit          hin [3];
  bit          hout [3];
  logic [23:0] popd [3];
  int          nvec = 0;
  int          nbad = 0;
  always #5 clk = ~clk;
  pipe_reg_elastic #(.WIDTH(24), .DEPTH(1)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(oc0));
  pipe_reg_elastic #(.WIDTH(24), .DEPTH(2), .RESET_VAL(24'h5A5A5A)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(oc1));
  pipe_reg_elastic #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hC3)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data[7:0]),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(oc2));
  always_comb begin
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
    ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
    od[0] = od0; od[1] = od1; od[2] = {16'h0, od2};
    occ[0] = {1'b0, oc0}; occ[1] = oc1; occ[2] = oc2;
  end
  function automatic int dep(int i);
    return i + 1;
  endfunction
  function automatic logic [23:0] msk(int i);
    return i == 2 ? 24'h0000FF : 24'hFFFFFF;
  endfunction
  function automatic logic [23:0] rv(int i);
    return i == 0 ? 24'h000000 : i == 1 ? 24'h5A5A5A : 24'h0000C3;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("occ%0d", i), 32'(occ[i]), 32'(cnt[i]));
      chk($sformatf("cap%0d", i), 32'(cnt[i] <= 2*dep(i)), 32'd1);
      if (ov[i]) begin
        chk($sformatf("nonempty%0d", i), 32'(cnt[i] > 0), 32'd1);
        chk($sformatf("data%0d", i), 32'(od[i]), 32'(mem[i][0]));
      end
      if (cnt[i] == 0) begin
        chk($sformatf("empty_ov%0d", i), 32'(ov[i]), 32'd0);
        chk($sformatf("empty_ir%0d", i), 32'(ir[i]), 32'd1);
      end
    end
  endtask
  task automatic step(input logic v, input logic [23:0] d, input logic r, input logic f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    for (int i = 0; i < 3; i++) begin
      hin[i] = v & ir[i];
      hout[i] = ov[i] & r;
      popd[i] = od[i];
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (f) cnt[i] = 0;
      else begin
        if (hout[i]) begin
          for (int k = 0; k < 7; k++) mem[i][k] = mem[i][k+1];
          cnt[i]--;
        end
        if (hin[i] && cnt[i] < 8) begin
          mem[i][cnt[i]] = d & msk(i);
          cnt[i]++;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask
  task automatic drain();
    for (int k = 0; k < 50 && (cnt[0] + cnt[1] + cnt[2]) != 0; k++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain", 32'(cnt[0] + cnt[1] + cnt[2]), 32'd0);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [23:0] d;
    int pops, acc2;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ov%0d", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst_ir%0d", i), 32'(ir[i]), 32'd1);
      chk($sformatf("rst_occ%0d", i), 32'(occ[i]), 32'd0);
      chk($sformatf("rst_od%0d", i), 32'(od[i]), 32'(rv(i)));
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step(n <= 8, 24'(n), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        if (n <= 8) chk($sformatf("stream_hs%0d", i), 32'(hin[i]), 32'd1);
        chk($sformatf("lat_ov%0d_%0d", i, n), 32'(ov[i]), 32'(n >= dep(i) && n < dep(i) + 8));
      end
      if (n >= 2 && n <= 8) chk("occ_steady1", 32'(occ[1]), 32'd2);
    end
    drain();
    d = 24'hA0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, d, 1'b0, 1'b0);
      if (hin[1]) d++;
      for (int i = 0; i < 3; i++)
        chk($sformatf("fill_ir%0d", i), 32'(ir[i]), 32'(cnt[i] < 2*dep(i)));
    end
    chk("full_occ1", 32'(occ[1]), 32'd4);
    chk("full_ir1", 32'(ir[1]), 32'd0);
    chk("full_od1", 32'(od[1]), 32'hA0);
    pops = 0;
    for (int k = 0; k < 40 && pops < 6; k++) begin
      step(d <= 24'hA5, d, 1'b1, 1'b0);
      if (hout[1]) begin
        chk("order1", 32'(popd[1]), 32'(24'hA0 + pops));
        pops++;
      end
      if (hin[1]) d++;
    end
    chk("drained_words1", 32'(pops), 32'd6);
    drain();
    acc2 = 0;
    for (int k = 0; k < 20000 && acc2 < 1000; k++) begin
      step(1'($urandom % 2), 24'($urandom), 1'($urandom % 2), 1'b0);
      if (hin[2]) acc2++;
    end
    chk("random_words2", 32'(acc2), 32'd1000);
    drain();
    for (int k = 0; k < 3; k++) step(1'b1, 24'h10 + 24'(k), 1'b0, 1'b0);
    step(1'b1, 24'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("flush_occ%0d", i), 32'(occ[i]), 32'd0);
      chk($sformatf("flush_ov%0d", i), 32'(ov[i]), 32'd0);
      chk($sformatf("flush_ir%0d", i), 32'(ir[i]), 32'd1);
    end
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 24'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_ov%0d", i), 32'(ov[i]), 32'd0);
      chk($sformatf("arst_occ%0d", i), 32'(occ[i]), 32'd0);
      chk($sformatf("arst_od%0d", i), 32'(od[i]), 32'(rv(i)));
      chk($sformatf("arst_ir%0d", i), 32'(ir[i]), 32'd1);
      cnt[i] = 0;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step(n == 1, 24'h123456, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        if (n == 1) chk($sformatf("post_hs%0d", i), 32'(hin[i]), 32'd1);
        chk($sformatf("post_ov%0d_%0d", i, n), 32'(ov[i]), 32'(n == dep(i)));
        if (n == dep(i)) chk($sformatf("post_od%0d", i), 32'(od[i]), 32'(24'h123456 & msk(i)));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
